// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and width helper for the UART transmitter.
// Holds FSM states, par_mode/stop_mode codes and clog2w().
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1H  = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;
  localparam logic [1:0] STOP_2B  = 2'b11;

  // Bits needed to hold values 0..n-1 (at least 1).
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_param.sv
// uart_tx_param: oversampled UART transmitter, DBIT data bits, 1/1.5/2 stop.
// Parity state and par_mode decoding built only with UART_TX_PARITY_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OS_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      par_mode,
  input  logic [1:0]      stop_mode,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  localparam int SW = clog2w(2 * OS_TICK);
  localparam int NW = clog2w(DBIT);

  localparam logic [SW-1:0] LIM_1  = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] LIM_1H = SW'(3 * OS_TICK / 2 - 1);
  localparam logic [SW-1:0] LIM_2  = SW'(2 * OS_TICK - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;
  logic [1:0]      stop_q, stop_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic            par_en_in;
  logic            par_bit_in;
  logic [SW-1:0]   stop_lim;
  logic [SW-1:0]   lim;
  logic            last;

`ifdef UART_TX_PARITY_EN
  assign par_en_in  = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
  assign par_bit_in = (^din) ^ (par_mode == PAR_ODD);
`else
  logic unused_par;
  assign par_en_in  = 1'b0;
  assign par_bit_in = 1'b0;
  assign unused_par = ^{par_mode, par_bit_q};
`endif

  // Tick budget of the current bit; stop length follows latched mode.
  always_comb begin
    stop_lim = LIM_2;
    case (stop_q)
      STOP_1:  stop_lim = LIM_1;
      STOP_1H: stop_lim = LIM_1H;
      default: stop_lim = LIM_2;
    endcase
    lim  = (state_q == ST_STOP) ? stop_lim : LIM_1;
    last = s_tick && (s_q == lim);
  end

  // Next state, counters, shifter and registered line level.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    if (state_q != ST_IDLE && s_tick) begin
      s_d = last ? '0 : s_q + SW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          state_d   = ST_START;
          s_d       = '0;
          n_d       = '0;
          b_d       = din;
          par_en_d  = par_en_in;
          par_bit_d = par_bit_in;
          stop_d    = stop_mode;
        end
      end
      ST_START: begin
        if (last) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last) begin
          b_d = b_q >> 1;
          if (n_q == NW'(DBIT - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            n_d = n_q + NW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (last) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_bit_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= STOP_1;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign din_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign tx           = tx_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: frame-level model of the UART transmitter vs two DUTs.
// Instances: DBIT=8 and DBIT=5, both OS_TICK=16.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic [1:0] dv = 2'b00;
  logic [7:0] din0 = 8'h00;
  logic [4:0] din1 = 5'h00;
  logic [1:0] pm [2];
  logic [1:0] sm [2];
  logic [1:0] rdy_o, tx_o, busy_o, done_o;

  int checks = 0;
  int failures = 0;
  logic obs [16];

  bit mbusy [2];
  bit mdone [2];
  int mc    [2];
  int mt    [2];
  int mdata [2];
  bit mpe   [2];
  bit mpar  [2];

  uart_tx_param #(.DBIT(8), .OS_TICK(16)) u8 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .din_valid(dv[0]), .din_ready(rdy_o[0]), .din(din0),
    .par_mode(pm[0]), .stop_mode(sm[0]),
    .tx(tx_o[0]), .busy(busy_o[0]), .tx_done_tick(done_o[0])
  );

  uart_tx_param #(.DBIT(5), .OS_TICK(16)) u5 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .din_valid(dv[1]), .din_ready(rdy_o[1]), .din(din1),
    .par_mode(pm[1]), .stop_mode(sm[1]),
    .tx(tx_o[1]), .busy(busy_o[1]), .tx_done_tick(done_o[1])
  );

  initial forever #5 clk = ~clk;

  // One s_tick every third cycle, free running (also while idle).
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 3;
      s_tick = (ph == 0);
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int nbits(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  // Line level at tick count c: segments of 16 ticks
  // start, data LSB first, optional parity, then stop high.
  function automatic bit exp_level(input int d, input int c);
    int seg, nb;
    seg = c / 16;
    nb  = nbits(d);
    if (seg == 0) return 1'b0;
    if (seg <= nb) return bit'((mdata[d] >> (seg - 1)) & 1);
    if (mpe[d] && seg == nb + 1) return mpar[d];
    return 1'b1;
  endfunction

  task automatic accept(input int d);
    int nb, x, st;
    logic [1:0] p, s;
    nb = nbits(d);
    mdata[d] = (d == 0) ? int'(din0) : int'(din1);
    p = pm[d];
    s = sm[d];
    mpe[d] = PAR_ON && (p == 2'd1 || p == 2'd2);
    x = 0;
    for (int i = 0; i < nb; i++) x = x ^ ((mdata[d] >> i) & 1);
    mpar[d] = bit'(x) ^ (p == 2'd2);
    st = (s == 2'd0) ? 16 : (s == 2'd1) ? 24 : 32;
    mt[d] = 16 * (1 + nb + int'(mpe[d])) + st;
  endtask

  // Frame model: acceptance, tick counting, completion.
  initial begin
    for (int d = 0; d < 2; d++) begin
      mbusy[d] = 0; mdone[d] = 0; mc[d] = 0; mt[d] = 0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          mbusy[d] = 0; mdone[d] = 0; mc[d] = 0;
        end else if (!mbusy[d]) begin
          mdone[d] = 0;
          if (dv[d]) begin
            accept(d);
            mbusy[d] = 1;
            mc[d] = 0;
          end
        end else if (s_tick) begin
          mc[d]++;
          if (mc[d] == mt[d]) begin
            mbusy[d] = 0;
            mdone[d] = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("tx%0d", d), int'(tx_o[d]),
            mbusy[d] ? int'(exp_level(d, mc[d])) : 1);
      check($sformatf("busy%0d", d), int'(busy_o[d]), int'(mbusy[d]));
      check($sformatf("ready%0d", d), int'(rdy_o[d]), int'(!mbusy[d]));
      check($sformatf("done%0d", d), int'(done_o[d]), int'(mdone[d]));
    end
  end

  task automatic start_req(input int d, input logic [7:0] data,
                           input logic [1:0] p, input logic [1:0] s,
                           input bit hold);
    int n;
    @(negedge clk);
    if (d == 0) din0 = data; else din1 = data[4:0];
    pm[d] = p;
    sm[d] = s;
    dv[d] = 1'b1;
    n = 0;
    while (!rdy_o[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL accept_timeout dut=%0d actual=busy required=ready", d);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      dv[d] = 1'b0;
      if (d == 0) din0 = ~data; else din1 = ~data[4:0];
      pm[d] = ~p;
      sm[d] = ~s;
    end
  endtask

  // Counts s_tick edges after the transfer edge until done (or stop_at).
  task automatic wait_done(input int d, input int stop_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 16; i++) obs[i] = 1'bx;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (s_tick) cnt++;
      @(negedge clk);
      if (cnt % 16 == 8 && cnt / 16 < 16) obs[cnt / 16] = tx_o[d];
      if (stop_at != 0 && cnt == stop_at) return;
      if (done_o[d]) return;
    end
    checks++; failures++;
    $display("FAIL done_timeout dut=%0d actual=no_done required=done", d);
  endtask

  initial begin
    int cnt;
    logic [9:0] pat;
    pm[0] = 2'd0; pm[1] = 2'd0;
    sm[0] = 2'd0; sm[1] = 2'd0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tx", int'(tx_o), 3);
    check("rst_busy", int'(busy_o), 0);
    check("rst_ready", int'(rdy_o), 3);
    check("rst_done", int'(done_o), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 0x55, no parity, one stop
    start_req(0, 8'h55, 2'd0, 2'd0, 0);
    wait_done(0, 0, cnt);
    check("t55_ticks", cnt, 160);
    pat = 10'b1010101010;
    for (int i = 0; i < 10; i++)
      check($sformatf("t55_bit%0d", i), int'(obs[i]), int'(pat[i]));

    // 0x07 even parity, two stop
    start_req(0, 8'h07, 2'd1, 2'd2, 0);
    wait_done(0, 0, cnt);
    check("t07e_ticks", cnt, PAR_ON ? 192 : 176);
    check("t07e_par", int'(obs[9]), 1);

    // 0x07 odd parity, two stop
    start_req(0, 8'h07, 2'd2, 2'd2, 0);
    wait_done(0, 0, cnt);
    check("t07o_ticks", cnt, PAR_ON ? 192 : 176);
    check("t07o_par", int'(obs[9]), PAR_ON ? 0 : 1);

    // 0xA3, one-and-half stop
    start_req(0, 8'hA3, 2'd0, 2'd1, 0);
    wait_done(0, 0, cnt);
    check("tA3_ticks", cnt, 168);
    check("tA3_stop", int'(obs[9]), 1);

    // back-to-back with din_valid held
    start_req(0, 8'h3C, 2'd0, 2'd0, 1);
    din0 = 8'hC5; pm[0] = 2'd1; sm[0] = 2'd3;
    wait_done(0, 0, cnt);
    check("b2b_ticks1", cnt, 160);
    check("b2b_ready_at_done", int'(rdy_o[0]), 1);
    @(posedge clk);
    #1;
    check("b2b_start_tx", int'(tx_o[0]), 0);
    check("b2b_ready_after", int'(rdy_o[0]), 0);
    dv[0] = 1'b0; din0 = 8'h00; pm[0] = 2'd0; sm[0] = 2'd0;
    wait_done(0, 0, cnt);
    check("b2b_ticks2", cnt, PAR_ON ? 192 : 176);

    // reset during data bit 3, then a clean frame
    start_req(0, 8'hA3, 2'd0, 2'd0, 0);
    wait_done(0, 72, cnt);
    check("mid_reached", cnt, 72);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tx", int'(tx_o[0]), 1);
    check("mid_rst_busy", int'(busy_o[0]), 0);
    check("mid_rst_done", int'(done_o[0]), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start_req(0, 8'h96, 2'd2, 2'd0, 0);
    wait_done(0, 0, cnt);
    check("post_rst_ticks", cnt, PAR_ON ? 176 : 160);
    check("post_rst_par", int'(obs[9]), 1);

    // DBIT=5 instance, odd parity
    start_req(1, 8'h1F, 2'd2, 2'd0, 0);
    wait_done(1, 0, cnt);
    check("d5_ticks", cnt, PAR_ON ? 128 : 112);
    check("d5_par", int'(obs[6]), PAR_ON ? 0 : 1);
    for (int i = 1; i < 6; i++)
      check($sformatf("d5_bit%0d", i), int'(obs[i]), 1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OS_TICK, default 16, s_tick pulses per bit period; even, >= 4.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_tick  input  1  oversample tick, one clk wide, from baud generator.
REQ-006 din_valid  input  1  frame request; held until accepted.
REQ-007 din_ready  output  1  block can accept a frame this cycle.
REQ-008 din  input  DBIT  payload, LSB transmitted first.
REQ-009 par_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-010 stop_mode  input  2  00 one, 01 one-and-half, 10 two, 11 two stop bits.
REQ-011 tx  output  1  serial line, registered, idle high.
REQ-012 busy  output  1  high from acceptance until the frame completes.
REQ-013 tx_done_tick  output  1  one-clk pulse at frame end.

Function
REQ-014 States: IDLE, START, DATA, PARITY, STOP; no other reachable state.
REQ-015 din_ready SHALL be high only in IDLE; transfer occurs when din_valid && din_ready at a clk edge.
REQ-016 On transfer: latch din, par_mode, stop_mode; clear tick and bit counters; enter START; tx low from that same edge.
REQ-017 Input changes after transfer SHALL not affect the frame in flight; din_valid while busy is ignored.
REQ-018 Counters advance only on clk edges with s_tick high; s_tick in IDLE has no effect.
REQ-019 START: tx low for OS_TICK ticks, then DATA.
REQ-020 DATA: DBIT bits, LSB first, OS_TICK ticks each; after bit DBIT-1 go to PARITY if latched parity enabled, else STOP.
REQ-021 PARITY: one bit for OS_TICK ticks; even = XOR of all DBIT data bits, odd = its inverse.
REQ-022 STOP: tx high for OS_TICK, 3*OS_TICK/2 or 2*OS_TICK ticks per latched stop_mode.
REQ-023 On the edge counting the final stop tick: tx_done_tick high for that cycle, state to IDLE, busy low, din_ready high next cycle.
REQ-024 Back-to-back: a frame presented with din_valid already high SHALL be accepted on the first cycle in IDLE, with no extra idle bit time.
REQ-025 Tick counter width SHALL cover 2*OS_TICK-1 without overflow; bit counter covers DBIT-1.

Reset
REQ-026 On reset (asynchronous, any state): state IDLE, tx 1, busy 0, tx_done_tick 0, din_ready 1 after release, counters and shift register 0.
REQ-027 Reset mid-frame SHALL abort the frame with no tx_done_tick.

Configuration
REQ-028 Macro UART_TX_PARITY_EN: defined -> PARITY state and par_mode decoding built as above.
REQ-029 Undefined -> PARITY state not built, par_mode ignored, frames always no-parity; ports unchanged.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state encoding, par_mode and stop_mode encodings, and the clog2 width helper.
REQ-031 Single module, no sub-module; parity is an inline reduction XOR.

Verification (DBIT=8, OS_TICK=16, parity enabled)
REQ-032 0x55, par 00, stop 00 -> tx 0,1,0,1,0,1,0,1,0,1 per 16 ticks; tx_done_tick on tick 160.
REQ-033 0x07, par 01 then par 10 -> parity bit 1 then 0; stop 10 -> done on tick 192.
REQ-034 0xA3, par 00, stop 01 -> stop high 24 ticks, done on tick 168.
REQ-035 Two frames with din_valid held high -> second start bit falls on the cycle after the first tx_done_tick; din_ready high one cycle.
REQ-036 Reset asserted during data bit 3 -> tx 1 immediately, no tx_done_tick, next frame transmits correctly.
REQ-037 DBIT=5, 0x1F, par 10 -> 5 data bits, parity 0, done on tick 128.
